split_arbiter: RTL

SPLIT_ARBITER -- requirements
Module: split_arbiter

---
 rtl/split_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/split_arbiter.sv
// Two-master bus arbiter with round-robin grants and split-transaction deferral/resume.
// Every grant is followed by one dead IDLE cycle; all outputs come from registers.
module split_arbiter #(
   parameter bit SPLIT_EN = 1'b1
) (
   input  logic clk,
   input  logic rstn,
   input  logic m1_breq,
   input  logic m2_breq,
   input  logic split_req,
   input  logic split_rdy,
   output logic m1_bgrant,
   output logic m2_bgrant,
   output logic m1_split,
   output logic m2_split,
   output logic split_grant,
   output logic msel,
   output logic bus_busy
);

   typedef enum logic [1:0] {StIdle, StGnt1, StGnt2} state_e;

   state_e state_q;
   logic   last_gnt_q;   // 0 = M1, 1 = M2
   logic   spl_pend_q;
   logic   spl_own_q;    // 0 = M1, 1 = M2
   logic   m1_split_q;
   logic   m2_split_q;
   logic   split_grant_q;
   logic   msel_q;

   logic own_breq;
   logic req1;
   logic req2;
   logic cur_m;
   logic cur_breq;

   assign own_breq = spl_own_q ? m2_breq : m1_breq;
   assign req1     = m1_breq & ~m1_split_q;
   assign req2     = m2_breq & ~m2_split_q;
   assign cur_m    = (state_q == StGnt2);
   assign cur_breq = cur_m ? m2_breq : m1_breq;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= StIdle;
         last_gnt_q    <= 1'b1;
         spl_pend_q    <= 1'b0;
         spl_own_q     <= 1'b0;
         m1_split_q    <= 1'b0;
         m2_split_q    <= 1'b0;
         split_grant_q <= 1'b0;
         msel_q        <= 1'b0;
      end else begin
         // Split owner abandoned its deferred transaction: forget it
         if (spl_pend_q && !own_breq) begin
            spl_pend_q <= 1'b0;
            m1_split_q <= 1'b0;
            m2_split_q <= 1'b0;
         end
         case (state_q)
            StIdle: begin
               if (spl_pend_q && split_rdy && own_breq) begin
                  state_q       <= spl_own_q ? StGnt2 : StGnt1;
                  msel_q        <= spl_own_q;
                  last_gnt_q    <= spl_own_q;
                  split_grant_q <= 1'b1;
                  spl_pend_q    <= 1'b0;
                  m1_split_q    <= 1'b0;
                  m2_split_q    <= 1'b0;
               end else if (req1 && (!req2 || last_gnt_q)) begin
                  state_q    <= StGnt1;
                  msel_q     <= 1'b0;
                  last_gnt_q <= 1'b0;
               end else if (req2) begin
                  state_q    <= StGnt2;
                  msel_q     <= 1'b1;
                  last_gnt_q <= 1'b1;
               end
            end
            StGnt1, StGnt2: begin
               if (!cur_breq) begin
                  state_q       <= StIdle;
                  split_grant_q <= 1'b0;
               end else if (SPLIT_EN && split_req && !spl_pend_q) begin
                  state_q       <= StIdle;
                  split_grant_q <= 1'b0;
                  spl_pend_q    <= 1'b1;
                  spl_own_q     <= cur_m;
                  if (cur_m) m2_split_q <= 1'b1;
                  else       m1_split_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign m1_bgrant   = (state_q == StGnt1);
   assign m2_bgrant   = (state_q == StGnt2);
   assign m1_split    = m1_split_q;
   assign m2_split    = m2_split_q;
   assign split_grant = split_grant_q;
   assign msel        = msel_q;
   assign bus_busy    = (state_q != StIdle);

endmodule
